// File: rtl/dl_reg_en_arst.sv
`default_nettype none
// ============================================================================
// Module      : dl_reg_en_arst
// Description : Edge-triggered data register with load enable and
//               asynchronous active-high reset to a programmable constant.
//               NUM_STAGES > 1 builds an enable-gated delay line from
//               identical register stages that all share one enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_reg_en_arst #(
    parameter int          NUM_BITS   = 32,
    parameter logic [31:0] RST_VAL    = 32'hdeadbeef,
    parameter int          NUM_STAGES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_BITS-1:0] d,
    output logic [NUM_BITS-1:0] q
);

    // Reset constant fitted to the data width: the cast truncates when the
    // register is narrower than 32 bits and zero-extends when it is wider.
    localparam logic [NUM_BITS-1:0] C_RST_VAL = NUM_BITS'(RST_VAL);

    // One register per stage. Each stage keeps its own flop so that every
    // element has exactly one driver; stage 0 takes d, later stages take the
    // previous stage's flop output, so a single enabled edge advances the
    // whole chain by one position.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic [NUM_BITS-1:0] stage_d;
        logic [NUM_BITS-1:0] stage_q;

        if (gi == 0) begin : g_head
            assign stage_d = d;
        end else begin : g_tail
            assign stage_d = g_stage[gi-1].stage_q;
        end

        // Async reset wins over enable and over a coincident clock edge;
        // with en low the stage simply holds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= C_RST_VAL;
            end else if (en) begin
                stage_q <= stage_d;
            end
        end
    end

    // Output comes straight from the last flop; no combinational path from
    // d or en reaches q.
    assign q = g_stage[NUM_STAGES-1].stage_q;

endmodule
`default_nettype wire

// File: tb/tb_dl_reg_en_arst.sv
`default_nettype none
// ============================================================================
// Module      : tb_dl_reg_en_arst
// Description : Self-checking bench for dl_reg_en_arst. Three instances share
//               the same stimulus: default (32b x1), a 3-stage delay line,
//               and an 8-bit 2-stage line that sees the truncated reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_reg_en_arst;

    localparam logic [31:0] C_RST   = 32'hdeadbeef;
    localparam logic [7:0]  C_RST8  = 8'hef;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] d = 32'h0;
    logic [31:0] q1;
    logic [31:0] q3;
    logic [7:0]  q8;

    int total = 0;
    int bad   = 0;

    // Expected values travel through this queue: pushed at drive time,
    // popped after the edge that should produce them.
    logic [31:0] sbq[$];

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] d;
        logic        sel;   // 0: single-stage instance, 1: 3-stage instance
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t tv[$];

    dl_reg_en_arst dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (q1)
    );

    dl_reg_en_arst #(
        .NUM_BITS   (32),
        .RST_VAL    (C_RST),
        .NUM_STAGES (3)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (q3)
    );

    dl_reg_en_arst #(
        .NUM_BITS   (8),
        .RST_VAL    (C_RST),
        .NUM_STAGES (2)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d[7:0]),
        .q   (q8)
    );

    // Gated clock so the reset path can be checked with the clock stopped.
    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_check(input string nm, input logic [31:0] act);
        logic [31:0] exp;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h expected <entry>", nm, act);
        end else begin
            exp = sbq.pop_front();
            check(nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [31:0] dv,
                       input logic s, input logic [31:0] ex, input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.d = dv; v.sel = s; v.exp = ex; v.nm = nm;
        tv.push_back(v);
    endtask

    // Apply table entries lo..hi, one clock edge each.
    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst = tv[i].rst;
            en  = tv[i].en;
            d   = tv[i].d;
            sbq.push_back(tv[i].exp);
            @(posedge clk);
            #1;
            pop_check(tv[i].nm, tv[i].sel ? q3 : q1);
        end
    endtask

    logic [31:0] m1;
    logic [31:0] m3 [3];
    logic [7:0]  m8 [2];

    initial begin
        // ---- table: single-stage reset hold, load, hold, reload; 3-stage pipe
        add(1, 1, 32'h12345678, 0, C_RST,        "rst_hold0");   // 0
        add(1, 1, 32'h12345678, 0, C_RST,        "rst_hold1");   // 1
        add(1, 1, 32'h12345678, 0, C_RST,        "rst_hold2");   // 2
        add(0, 1, 32'ha5a5a5a5, 0, 32'ha5a5a5a5, "load");        // 3
        add(0, 0, 32'hffffffff, 0, 32'ha5a5a5a5, "hold0");       // 4
        add(0, 0, 32'hffffffff, 0, 32'ha5a5a5a5, "hold1");       // 5
        add(0, 0, 32'hffffffff, 0, 32'ha5a5a5a5, "hold2");       // 6
        add(0, 0, 32'hffffffff, 0, 32'ha5a5a5a5, "hold3");       // 7
        add(0, 0, 32'hffffffff, 0, 32'ha5a5a5a5, "hold4");       // 8
        add(0, 1, 32'hffffffff, 0, 32'hffffffff, "reload");      // 9
        add(1, 1, 32'h00000009, 1, C_RST,        "pipe_rst");    // 10
        add(0, 1, 32'h00000001, 1, C_RST,        "pipe_d1");     // 11
        add(0, 1, 32'h00000002, 1, C_RST,        "pipe_d2");     // 12
        add(0, 1, 32'h00000003, 1, 32'h00000001, "pipe_d3");     // 13
        add(0, 1, 32'h00000004, 1, 32'h00000002, "pipe_d4");     // 14
        add(0, 0, 32'h00000005, 1, 32'h00000002, "pipe_hold0");  // 15
        add(0, 0, 32'h00000006, 1, 32'h00000002, "pipe_hold1");  // 16

        // ---- reset with the clock stopped: value appears at once
        #3;
        rst = 1'b1;
        #1;
        check("arst_noclk_q1", q1, C_RST);
        check("arst_noclk_q3", q3, C_RST);
        check("arst_noclk_q8", {24'h0, q8}, {24'h0, C_RST8});
        clk_run = 1'b1;

        // ---- reset held across enabled edges, then load
        run_vectors(0, 3);

        // ---- d changes mid-cycle: q must not follow until an enabled edge
        en = 1'b0;
        #2;
        d = 32'h0;
        #1;
        check("mid_cycle_d", q1, 32'ha5a5a5a5);

        // ---- hold for 5 edges, reload on the 6th
        run_vectors(4, 9);

        // ---- async reset pulse between edges
        rst = 1'b0; en = 1'b1; d = 32'h1;
        @(posedge clk);
        #1;
        check("pre_pulse_q1", q1, 32'h1);
        en = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("pulse_q1", q1, C_RST);
        check("pulse_q3", q3, C_RST);
        #1;
        rst = 1'b0; en = 1'b1; d = 32'h2;
        @(posedge clk);
        #1;
        check("post_release_q1", q1, 32'h2);

        // ---- 3-stage pipeline fill and hold
        run_vectors(10, 16);

        // ---- random soak against a golden model of all three instances
        for (int c = 0; c < 500; c++) begin
            logic        r;
            logic        e;
            logic [31:0] dv;
            r  = (c == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
            e  = 1'($urandom_range(0, 1));
            dv = $urandom;
            rst = r; en = e; d = dv;
            if (r) begin
                m1 = C_RST;
                for (int k = 0; k < 3; k++) m3[k] = C_RST;
                for (int k = 0; k < 2; k++) m8[k] = C_RST8;
            end else if (e) begin
                m1    = dv;
                m3[2] = m3[1];
                m3[1] = m3[0];
                m3[0] = dv;
                m8[1] = m8[0];
                m8[0] = dv[7:0];
            end
            sbq.push_back(m1);
            sbq.push_back(m3[2]);
            sbq.push_back({24'h0, m8[1]});
            if (r) begin
                #1;
                check("soak_arst_q1", q1, C_RST);
            end
            @(posedge clk);
            #1;
            pop_check("soak_q1", q1);
            pop_check("soak_q3", q3);
            pop_check("soak_q8", {24'h0, q8});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
